// File: rtl/ysyx_idu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_idu_pkg
// Description : Shared RV32I/E decode constants: opcodes, instruction-class
//               codes, immediate-format selectors and special encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_idu_pkg;

    // Major opcodes (inst[6:0]); bits [1:0] are always 2'b11 for 32-bit insts
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

    // Instruction class codes presented on opcls_o
    localparam logic [3:0] c_CLS_LUI    = 4'd0;
    localparam logic [3:0] c_CLS_AUIPC  = 4'd1;
    localparam logic [3:0] c_CLS_JAL    = 4'd2;
    localparam logic [3:0] c_CLS_JALR   = 4'd3;
    localparam logic [3:0] c_CLS_BRANCH = 4'd4;
    localparam logic [3:0] c_CLS_LOAD   = 4'd5;
    localparam logic [3:0] c_CLS_STORE  = 4'd6;
    localparam logic [3:0] c_CLS_OPIMM  = 4'd7;
    localparam logic [3:0] c_CLS_OP     = 4'd8;
    localparam logic [3:0] c_CLS_FENCE  = 4'd9;
    localparam logic [3:0] c_CLS_SYSTEM = 4'd10;
    localparam logic [3:0] c_CLS_NONE   = 4'd15;

    // ALU operation for non-ALU instructions
    localparam logic [3:0] c_ALU_NONE   = 4'b0000;

    // Immediate format selectors
    localparam logic [2:0] c_IMM_NONE   = 3'd0;
    localparam logic [2:0] c_IMM_I      = 3'd1;
    localparam logic [2:0] c_IMM_S      = 3'd2;
    localparam logic [2:0] c_IMM_B      = 3'd3;
    localparam logic [2:0] c_IMM_U      = 3'd4;
    localparam logic [2:0] c_IMM_J      = 3'd5;

    // Exact encodings of the environment-call instructions
    localparam logic [31:0] c_INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] c_INST_EBREAK = 32'h0010_0073;

endpackage
`default_nettype wire

// File: rtl/ysyx_idu_dec.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_idu_dec
// Description : Purely combinational RV32I/E decoder: register indices,
//               sign-extended immediate, ALU op, class, side-effect flags
//               and illegal-instruction detection.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_idu_dec
    import ysyx_idu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RV32E  = 0
) (
    input  logic [31:0]       i_inst,
    output logic [4:0]        o_rs1,
    output logic [4:0]        o_rs2,
    output logic [4:0]        o_rd,
    output logic [DATA_W-1:0] o_imm,
    output logic [3:0]        o_alu_op,
    output logic [3:0]        o_opcls,
    output logic              o_wen,
    output logic              o_mem_ren,
    output logic              o_mem_wen,
    output logic              o_ecall,
    output logic              o_ebreak,
    output logic              o_ill
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_funct7_b5;
    logic [3:0]  w_cls;
    logic [2:0]  w_imm_sel;
    logic        w_known;
    logic        w_f3_ok;
    logic        w_writes;
    logic        w_use_rd;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_e_bad;
    logic [31:0] w_imm32;

    assign w_opcode    = i_inst[6:0];
    assign w_funct3    = i_inst[14:12];
    assign w_funct7_b5 = i_inst[30];

    assign o_rs1 = i_inst[19:15];
    assign o_rs2 = i_inst[24:20];
    assign o_rd  = i_inst[11:7];

    // Opcode classification: class, immediate format, which register fields
    // are architecturally used, and whether funct3 is a defined encoding.
    // A non-11 low opcode pair never matches any case item, so it lands in
    // the default and is reported illegal.
    always_comb begin
        w_cls     = c_CLS_NONE;
        w_imm_sel = c_IMM_NONE;
        w_known   = 1'b0;
        w_f3_ok   = 1'b1;
        w_writes  = 1'b0;
        w_use_rd  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_opcode)
            c_OPC_LUI: begin
                w_cls = c_CLS_LUI;   w_imm_sel = c_IMM_U; w_known = 1'b1;
                w_writes = 1'b1;     w_use_rd = 1'b1;
            end
            c_OPC_AUIPC: begin
                w_cls = c_CLS_AUIPC; w_imm_sel = c_IMM_U; w_known = 1'b1;
                w_writes = 1'b1;     w_use_rd = 1'b1;
            end
            c_OPC_JAL: begin
                w_cls = c_CLS_JAL;   w_imm_sel = c_IMM_J; w_known = 1'b1;
                w_writes = 1'b1;     w_use_rd = 1'b1;
            end
            c_OPC_JALR: begin
                w_cls = c_CLS_JALR;  w_imm_sel = c_IMM_I; w_known = 1'b1;
                w_writes = 1'b1;     w_use_rd = 1'b1;  w_use_rs1 = 1'b1;
                w_f3_ok = (w_funct3 == 3'b000);
            end
            c_OPC_BRANCH: begin
                w_cls = c_CLS_BRANCH; w_imm_sel = c_IMM_B; w_known = 1'b1;
                w_use_rs1 = 1'b1;     w_use_rs2 = 1'b1;
                w_f3_ok = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
            end
            c_OPC_LOAD: begin
                w_cls = c_CLS_LOAD;  w_imm_sel = c_IMM_I; w_known = 1'b1;
                w_writes = 1'b1;     w_use_rd = 1'b1;  w_use_rs1 = 1'b1;
                w_f3_ok = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) &&
                          (w_funct3 != 3'b111);
            end
            c_OPC_STORE: begin
                w_cls = c_CLS_STORE; w_imm_sel = c_IMM_S; w_known = 1'b1;
                w_use_rs1 = 1'b1;    w_use_rs2 = 1'b1;
                w_f3_ok = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) ||
                          (w_funct3 == 3'b010);
            end
            c_OPC_OPIMM: begin
                w_cls = c_CLS_OPIMM; w_imm_sel = c_IMM_I; w_known = 1'b1;
                w_writes = 1'b1;     w_use_rd = 1'b1;  w_use_rs1 = 1'b1;
            end
            c_OPC_OP: begin
                w_cls = c_CLS_OP;    w_known = 1'b1;
                w_writes = 1'b1;     w_use_rd = 1'b1;
                w_use_rs1 = 1'b1;    w_use_rs2 = 1'b1;
            end
            c_OPC_FENCE: begin
                // FENCE and FENCE.I only
                w_cls = c_CLS_FENCE; w_known = 1'b1;
                w_f3_ok = (w_funct3 == 3'b000) || (w_funct3 == 3'b001);
            end
            c_OPC_SYSTEM: begin
                // funct3==0 covers ecall/ebreak/xRET/WFI; others are CSR ops
                w_cls = c_CLS_SYSTEM; w_imm_sel = c_IMM_I; w_known = 1'b1;
                w_writes  = (w_funct3 != 3'b000);
                w_use_rd  = 1'b1;     w_use_rs1 = 1'b1;
                w_f3_ok   = (w_funct3 != 3'b100);
            end
            default: begin
                w_known = 1'b0;
            end
        endcase
    end

    // Immediate assembly in 32 bits; sign bit is always inst[31]
    always_comb begin
        w_imm32 = 32'd0;
        case (w_imm_sel)
            c_IMM_I: w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            c_IMM_S: w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            c_IMM_B: w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                                i_inst[30:25], i_inst[11:8], 1'b0};
            c_IMM_U: w_imm32 = {i_inst[31:12], 12'd0};
            c_IMM_J: w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                                i_inst[20], i_inst[30:21], 1'b0};
            default: w_imm32 = 32'd0;
        endcase
    end

    assign o_imm = DATA_W'($signed(w_imm32));

    // ALU op: funct7[5] only distinguishes SUB/SRA and SRAI from SRLI
    always_comb begin
        o_alu_op = c_ALU_NONE;
        if (w_cls == c_CLS_OP) begin
            o_alu_op = {w_funct7_b5, w_funct3};
        end else if (w_cls == c_CLS_OPIMM) begin
            o_alu_op = {w_funct7_b5 & (w_funct3 == 3'b101), w_funct3};
        end
    end

    // RV32E: only the 16 low registers exist, and only fields the format
    // actually uses are checked (e.g. U-type immediate bits are not indices)
    assign w_e_bad = (RV32E != 0) &&
                     ((w_use_rd  && i_inst[11]) ||
                      (w_use_rs1 && i_inst[19]) ||
                      (w_use_rs2 && i_inst[24]));

    assign o_ill     = !w_known || !w_f3_ok || w_e_bad;
    assign o_ecall   = (i_inst == c_INST_ECALL);
    assign o_ebreak  = (i_inst == c_INST_EBREAK);
    assign o_opcls   = w_cls;
    assign o_wen     = w_writes && (o_rd != 5'd0) && !o_ill;
    assign o_mem_ren = (w_cls == c_CLS_LOAD)  && !o_ill;
    assign o_mem_wen = (w_cls == c_CLS_STORE) && !o_ill;

endmodule
`default_nettype wire

// File: rtl/ysyx_idu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_idu
// Description : Decode stage. 2-entry skid buffer between fetch and execute
//               valid/ready handshakes; decodes the head entry. Flush drops
//               everything buffered plus any beat offered that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_idu
    import ysyx_idu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RV32E  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prev_valid,
    output logic              ready_o,
    input  logic [DATA_W-1:0] inst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic              valid_o,
    input  logic              next_ready,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [4:0]        rd_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [3:0]        alu_op_o,
    output logic [3:0]        opcls_o,
    output logic              wen_o,
    output logic              mem_ren_o,
    output logic              mem_wen_o,
    output logic              ecall_o,
    output logic              ebreak_o,
    output logic              ill_inst_o
);

    logic [ADDR_W-1:0] r_pc   [2];
    logic [DATA_W-1:0] r_inst [2];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [1:0]        r_count;

    logic              w_enq;
    logic              w_deq;
    logic              w_wen;
    logic              w_mem_ren;
    logic              w_mem_wen;
    logic              w_ecall;
    logic              w_ebreak;

    // Handshake outputs come from registered state only (plus reset)
    assign ready_o = !rst && (r_count != 2'd2);
    assign valid_o = !rst && (r_count != 2'd0);

    assign w_enq = prev_valid && ready_o && !flush;
    assign w_deq = valid_o && next_ready;

    // Occupancy and pointer update; reset, then flush, take priority
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else if (flush) begin
            r_count  <= 2'd0;
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_deq) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage: payload only, no reset needed
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_pc[r_wr_ptr]   <= pc;
            r_inst[r_wr_ptr] <= inst;
        end
    end

    assign pc_o   = r_pc[r_rd_ptr];
    assign inst_o = r_inst[r_rd_ptr];

    ysyx_idu_dec #(
        .DATA_W (DATA_W),
        .RV32E  (RV32E)
    ) u_dec (
        .i_inst    (inst_o[31:0]),
        .o_rs1     (rs1_o),
        .o_rs2     (rs2_o),
        .o_rd      (rd_o),
        .o_imm     (imm_o),
        .o_alu_op  (alu_op_o),
        .o_opcls   (opcls_o),
        .o_wen     (w_wen),
        .o_mem_ren (w_mem_ren),
        .o_mem_wen (w_mem_wen),
        .o_ecall   (w_ecall),
        .o_ebreak  (w_ebreak),
        .o_ill     (ill_inst_o)
    );

    // Side-effect flags are forced low on empty so stale/unknown entries
    // can never trigger writes downstream
    assign wen_o     = valid_o && w_wen;
    assign mem_ren_o = valid_o && w_mem_ren;
    assign mem_wen_o = valid_o && w_mem_wen;
    assign ecall_o   = valid_o && w_ecall;
    assign ebreak_o  = valid_o && w_ebreak;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_idu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_idu
// Description : Directed self-checking bench for the decode stage skid
//               buffer and decoder; a second instance runs with RV32E=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_idu;
    import ysyx_idu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        prev_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        flush;
    logic        next_ready;

    logic        ready_o, valid_o, wen_o, mem_ren_o, mem_wen_o;
    logic        ecall_o, ebreak_o, ill_inst_o;
    logic [31:0] pc_o, inst_o, imm_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [3:0]  alu_op_o, opcls_o;

    logic        e_ready, e_valid, e_wen, e_mem_ren, e_mem_wen;
    logic        e_ecall, e_ebreak, e_ill;
    logic [31:0] e_pc, e_inst, e_imm;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [3:0]  e_alu_op, e_opcls;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ysyx_idu #(.ADDR_W(32), .DATA_W(32), .RV32E(0)) u_dut (
        .clk(clk), .rst(rst), .prev_valid(prev_valid), .ready_o(ready_o),
        .inst(inst), .pc(pc), .flush(flush), .valid_o(valid_o),
        .next_ready(next_ready), .pc_o(pc_o), .inst_o(inst_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .imm_o(imm_o),
        .alu_op_o(alu_op_o), .opcls_o(opcls_o), .wen_o(wen_o),
        .mem_ren_o(mem_ren_o), .mem_wen_o(mem_wen_o), .ecall_o(ecall_o),
        .ebreak_o(ebreak_o), .ill_inst_o(ill_inst_o)
    );

    ysyx_idu #(.ADDR_W(32), .DATA_W(32), .RV32E(1)) u_dut_e (
        .clk(clk), .rst(rst), .prev_valid(prev_valid), .ready_o(e_ready),
        .inst(inst), .pc(pc), .flush(flush), .valid_o(e_valid),
        .next_ready(next_ready), .pc_o(e_pc), .inst_o(e_inst),
        .rs1_o(e_rs1), .rs2_o(e_rs2), .rd_o(e_rd), .imm_o(e_imm),
        .alu_op_o(e_alu_op), .opcls_o(e_opcls), .wen_o(e_wen),
        .mem_ren_o(e_mem_ren), .mem_wen_o(e_mem_wen), .ecall_o(e_ecall),
        .ebreak_o(e_ebreak), .ill_inst_o(e_ill)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat for exactly one cycle
    task automatic push(input logic [31:0] i, input logic [31:0] p);
        prev_valid = 1'b1;
        inst       = i;
        pc         = p;
        tick();
        prev_valid = 1'b0;
    endtask

    // Accept the head for exactly one cycle
    task automatic pop();
        next_ready = 1'b1;
        tick();
        next_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        prev_valid = 1'b1;
        inst       = 32'h0050_0093;
        pc         = 32'h8000_0000;
        flush      = 1'b0;
        next_ready = 1'b0;

        // Reset held 3 cycles while fetch offers a beat
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_valid", valid_o, 1'b0);
            chk("rst_ready", ready_o, 1'b0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_ready", ready_o, 1'b1);
        chk("post_rst_valid", valid_o, 1'b0);

        // addi x1,x0,5 is still offered: accepted at this edge
        tick();
        prev_valid = 1'b0;
        chk("addi_valid",  valid_o,  1'b1);
        chk("addi_rd",     rd_o,     5'd1);
        chk("addi_rs1",    rs1_o,    5'd0);
        chk("addi_imm",    imm_o,    32'd5);
        chk("addi_cls",    opcls_o,  c_CLS_OPIMM);
        chk("addi_alu",    alu_op_o, 4'b0000);
        chk("addi_wen",    wen_o,    1'b1);
        chk("addi_pc",     pc_o,     32'h8000_0000);
        chk("addi_ill",    ill_inst_o, 1'b0);
        pop();
        chk("addi_drained", valid_o, 1'b0);

        // lui then beq with execute stalled: buffer fills
        push(32'h1234_5137, 32'h8000_0004);
        push(32'hFE00_0EE3, 32'h8000_0008);
        chk("full_ready", ready_o,  1'b0);
        chk("full_valid", valid_o,  1'b1);
        chk("lui_imm",    imm_o,    32'h1234_5000);
        chk("lui_cls",    opcls_o,  c_CLS_LUI);
        chk("lui_rd",     rd_o,     5'd2);
        chk("lui_wen",    wen_o,    1'b1);
        chk("lui_pc",     pc_o,     32'h8000_0004);
        pop();
        chk("beq_imm",    imm_o,    32'hFFFF_FFFC);
        chk("beq_cls",    opcls_o,  c_CLS_BRANCH);
        chk("beq_wen",    wen_o,    1'b0);
        chk("beq_pc",     pc_o,     32'h8000_0008);
        chk("beq_ready",  ready_o,  1'b1);
        pop();
        chk("beq_drained", valid_o, 1'b0);

        // Streaming: one in, one out every cycle; order and wrap preserved
        next_ready = 1'b1;
        prev_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            inst = {12'(10 + i), 5'd0, 3'b000, 5'(i + 1), 7'h13};
            pc   = 32'h0000_0100 + 32'(4 * i);
            tick();
            chk("stream_valid", valid_o, 1'b1);
            chk("stream_pc",    pc_o,    32'h0000_0100 + 32'(4 * i));
            chk("stream_imm",   imm_o,   32'(10 + i));
            chk("stream_ready", ready_o, 1'b1);
        end
        prev_valid = 1'b0;
        tick();
        next_ready = 1'b0;
        chk("stream_drained", valid_o, 1'b0);

        // Fill, then flush with a beat offered in the same cycle
        push(32'h0010_0093, 32'h0000_0200);
        push(32'h0020_0093, 32'h0000_0204);
        chk("pre_flush_full", ready_o, 1'b0);
        flush      = 1'b1;
        prev_valid = 1'b1;
        inst       = 32'h0030_0093;
        pc         = 32'h0000_0208;
        tick();
        flush      = 1'b0;
        prev_valid = 1'b0;
        chk("flush_valid", valid_o, 1'b0);
        chk("flush_ready", ready_o, 1'b1);
        // Flush while empty and ready: the offered beat is still dropped
        flush      = 1'b1;
        prev_valid = 1'b1;
        inst       = 32'h0040_0093;
        pc         = 32'h0000_020C;
        tick();
        flush      = 1'b0;
        prev_valid = 1'b0;
        chk("flush_drop_valid", valid_o, 1'b0);
        push(32'h0050_0093, 32'h0000_0210);
        chk("post_flush_pc",    pc_o,    32'h0000_0210);
        chk("post_flush_valid", valid_o, 1'b1);
        pop();
        chk("post_flush_drained", valid_o, 1'b0);

        // All-zero word is illegal and must not write
        push(32'h0000_0000, 32'h0000_0300);
        chk("zero_ill",  ill_inst_o, 1'b1);
        chk("zero_wen",  wen_o,      1'b0);
        chk("zero_mren", mem_ren_o,  1'b0);
        pop();

        push(32'h0010_0073, 32'h0000_0304);
        chk("ebreak",       ebreak_o,   1'b1);
        chk("ebreak_ecall", ecall_o,    1'b0);
        chk("ebreak_wen",   wen_o,      1'b0);
        chk("ebreak_ill",   ill_inst_o, 1'b0);
        chk("ebreak_cls",   opcls_o,    c_CLS_SYSTEM);
        pop();

        push(32'h0000_0073, 32'h0000_0308);
        chk("ecall",        ecall_o,  1'b1);
        chk("ecall_ebreak", ebreak_o, 1'b0);
        pop();

        // add x16,x1,x2: legal on RV32I, illegal on RV32E
        push(32'h0020_8833, 32'h0000_030C);
        chk("add16_ill_i",  ill_inst_o, 1'b0);
        chk("add16_ill_e",  e_ill,      1'b1);
        chk("add16_wen_i",  wen_o,      1'b1);
        chk("add16_wen_e",  e_wen,      1'b0);
        chk("add16_cls",    opcls_o,    c_CLS_OP);
        chk("add16_rd",     rd_o,       5'd16);
        pop();

        // sub x3,x1,x2 -> funct7[5] set in alu_op
        push(32'h4020_81B3, 32'h0000_0310);
        chk("sub_alu", alu_op_o, 4'b1000);
        chk("sub_rs2", rs2_o,    5'd2);
        pop();

        // sw x2,8(x1)
        push(32'h0020_A423, 32'h0000_0314);
        chk("sw_imm",  imm_o,     32'd8);
        chk("sw_mwen", mem_wen_o, 1'b1);
        chk("sw_wen",  wen_o,     1'b0);
        pop();

        // lw x5,-4(x1)
        push(32'hFFC0_A283, 32'h0000_0318);
        chk("lw_imm",  imm_o,     32'hFFFF_FFFC);
        chk("lw_mren", mem_ren_o, 1'b1);
        chk("lw_wen",  wen_o,     1'b1);
        chk("lw_alu",  alu_op_o,  4'b0000);
        pop();

        // jal x0,-8: J immediate, no write to x0
        push(32'hFF9F_F06F, 32'h0000_031C);
        chk("jal_imm", imm_o,   32'hFFFF_FFF8);
        chk("jal_cls", opcls_o, c_CLS_JAL);
        chk("jal_wen", wen_o,   1'b0);
        pop();
        chk("end_valid", valid_o, 1'b0);
        chk("end_mren",  mem_ren_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
